grant_hold: RTL and testbench

- Registered grant stage that sits directly downstream of the one-hot priority picker in the bus arbiter path.
- Captures the picker's one-hot `pick` vector and turns it into a stable, registered bus grant.
- Holds that grant while the owning master has transfers outstanding or still requests, and releases it on request drop or hold timeout.
- Supplies the encoded master index that steers the interconnect muxes.

---
 rtl/arb_pkg.sv | 37 +++
 rtl/onehot_to_bin.sv | 24 ++
 rtl/grant_hold.sv | 173 +++++++++++++++++
 tb/tb_grant_hold.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg -- shared definitions for the bus arbiter grant path.
//
// Contents:
//   IDLE / OWNED / RELEASE : state encodings of the grant-hold FSM
//   state_t                : enum built on those encodings
//   popcount()             : number of set bits in a vector (up to 32 bits)
//   onehot_check()         : true when zero or exactly one bit is set
package arb_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] OWNED   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_OWNED   = OWNED,
    ST_RELEASE = RELEASE
  } state_t;

  // Callers zero-extend their vector to this width, so request vectors
  // wider than 32 masters are not supported by these helpers.
  localparam int MAX_VEC_W = 32;

  function automatic int unsigned popcount(input logic [MAX_VEC_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_VEC_W; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

  function automatic logic onehot_check(input logic [MAX_VEC_W-1:0] v);
    return (popcount(v) <= 1);
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// onehot_to_bin -- combinational one-hot to binary index encoder.
//
// Ports:
//   onehot [W_INPUT]        : one-hot (or all-zero) input vector
//   bin    [clog2(W_INPUT)] : index of the set bit, 0 when input is zero
module onehot_to_bin #(
  parameter  int W_INPUT = 4,
  localparam int W_OUT   = (W_INPUT > 1) ? $clog2(W_INPUT) : 1
) (
  input  logic [W_INPUT-1:0] onehot,
  output logic [W_OUT-1:0]   bin
);

  // OR of the indices of all set bits; exact for one-hot or zero input.
  always_comb begin
    bin = '0;
    for (int i = 0; i < W_INPUT; i++) begin
      if (onehot[i]) begin
        bin = bin | W_OUT'(i);
      end
    end
  end

endmodule

// File: rtl/grant_hold.sv
// grant_hold -- registered grant stage behind the one-hot priority picker.
//
// Captures the picker's one-hot selection into a registered bus grant, holds
// it while the owner still requests or has transfers outstanding, and
// releases it on request drop or on hold timeout, with one dead turnaround
// cycle before the bus can be re-granted.
//
// Transfer interface (no back-pressure): xfer_start is a single-cycle strobe
// meaning the owner issued one transfer this cycle; xfer_done is a
// single-cycle strobe meaning one of the owner's transfers completed. Both
// high in the same cycle leave the outstanding count unchanged.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req        : raw master request bits
//   pick       : one-hot (or zero) selection from the priority picker
//   xfer_start : owner issues a transfer this cycle
//   xfer_done  : one owner transfer completes this cycle
//   gnt        : registered one-hot grant
//   gnt_idx    : registered binary index of gnt (0 when gnt is 0)
//   gnt_valid  : registered gnt != 0
//   timeout    : one-cycle pulse in the last owned cycle of a forced release
//   err        : sticky error (bad pick, outstanding overflow, stray start)
//   dbg_state  : current FSM state (IDLE/OWNED/RELEASE encodings)
module grant_hold
  import arb_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int W_OUTST   = 3,
  parameter int MAX_HOLD  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         req,
  input  logic [N_MASTERS-1:0]         pick,
  input  logic                         xfer_start,
  input  logic                         xfer_done,
  output logic [N_MASTERS-1:0]         gnt,
  output logic [$clog2(N_MASTERS)-1:0] gnt_idx,
  output logic                         gnt_valid,
  output logic                         timeout,
  output logic                         err,
  output logic [1:0]                   dbg_state
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [W_OUTST-1:0] OUT_MAX  = '1;
  localparam logic [HW-1:0]      HOLD_MAX = HW'(MAX_HOLD - 1);

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 valid_q;
  logic [W_OUTST-1:0]   outst_q, outst_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 err_q, err_d;
  logic                 timeout_c;
  logic                 owner_req;

  assign owner_req = |(req & gnt_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    outst_d   = outst_q;
    hold_d    = hold_q;
    err_d     = err_q;
    timeout_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        outst_d = '0;
        hold_d  = '0;
        if (xfer_start) begin
          err_d = 1'b1;
        end
        if (!onehot_check(32'(pick))) begin
          err_d = 1'b1;
        end else if (|(pick & req)) begin
          gnt_d   = pick;
          state_d = ST_OWNED;
        end
      end

      ST_OWNED: begin
        // Simultaneous start and done cancel out, so neither overflows.
        if (xfer_start && !xfer_done) begin
          if (outst_q == OUT_MAX) begin
            err_d = 1'b1;
          end else begin
            outst_d = outst_q + 1'b1;
          end
        end else if (xfer_done && !xfer_start && (outst_q != '0)) begin
          outst_d = outst_q - 1'b1;
        end

        // Release decisions look at the count after this cycle's update,
        // so the grant drops on the edge that retires the last transfer.
        if (outst_d != '0) begin
          hold_d = '0;
        end else if (hold_q == HOLD_MAX) begin
          timeout_c = 1'b1;
          state_d   = ST_RELEASE;
          gnt_d     = '0;
          hold_d    = '0;
        end else if (!owner_req) begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        // Bus turnaround: pick is deliberately not sampled here.
        state_d = ST_IDLE;
        gnt_d   = '0;
        hold_d  = '0;
        outst_d = '0;
        if (xfer_start) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        hold_d  = '0;
        outst_d = '0;
      end
    endcase
  end

  // Index is encoded from the next grant so gnt, gnt_idx and gnt_valid
  // all update on the same edge.
  onehot_to_bin #(
    .W_INPUT (N_MASTERS)
  ) u_enc (
    .onehot (gnt_d),
    .bin    (idx_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      outst_q <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= |gnt_d;
      outst_q <= outst_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_c;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_grant_hold.sv
module tb_grant_hold;

  localparam int N  = 4;
  localparam int WO = 3;
  localparam int MH = 16;
  localparam int IW = $clog2(N);
  localparam int EW = N + IW + 3;
  localparam int OMAX = (1 << WO) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]  req, pick;
  logic          xfer_start, xfer_done;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid, timeout, err;
  logic [1:0]    dbg_state;

  grant_hold #(.N_MASTERS(N), .W_OUTST(WO), .MAX_HOLD(MH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .pick       (pick),
    .xfer_start (xfer_start),
    .xfer_done  (xfer_done),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid),
    .timeout    (timeout),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- behavioural model ----------------
  int m_owner;   // granted master, -1 when bus is not owned
  bit m_dead;    // turnaround cycle after a release
  int m_outst;   // outstanding transfers of the owner
  int m_held;    // owned cycles with nothing outstanding
  bit m_err;

  logic [EW-1:0] exp_q[$];
  int n_vec, n_miss;
  logic last_timeout;

  task automatic model_reset();
    m_owner = -1; m_dead = 0; m_outst = 0; m_held = 0; m_err = 0;
  endtask

  function automatic int outst_after();
    if (xfer_start && !xfer_done) return (m_outst == OMAX) ? m_outst : m_outst + 1;
    if (xfer_done && !xfer_start && m_outst > 0) return m_outst - 1;
    return m_outst;
  endfunction

  function automatic logic [EW-1:0] model_expect();
    logic [N-1:0]  g;
    logic [IW-1:0] ix;
    logic          to;
    g = '0; ix = '0; to = 1'b0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      ix = IW'(m_owner);
      to = (outst_after() == 0) && (m_held == MH - 1);
    end
    return {to, m_err, (m_owner >= 0), ix, g};
  endfunction

  task automatic model_advance();
    int no;
    if (m_owner < 0 && !m_dead) begin
      if (xfer_start) m_err = 1;
      if ($countones(pick) > 1) m_err = 1;
      else if ((pick & req) != '0) begin
        for (int i = 0; i < N; i++) if (pick[i]) m_owner = i;
        m_outst = 0; m_held = 0;
      end
    end else if (m_dead) begin
      if (xfer_start) m_err = 1;
      m_dead = 0;
    end else begin
      if (xfer_start && !xfer_done && m_outst == OMAX) m_err = 1;
      no = outst_after();
      m_outst = no;
      if (no > 0) m_held = 0;
      else if (m_held == MH - 1 || !req[m_owner]) begin
        m_owner = -1; m_dead = 1; m_held = 0;
      end else m_held++;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_outputs();
    logic [EW-1:0] e, a;
    e = exp_q.pop_front();
    a = {timeout, err, gnt_valid, gnt_idx, gnt};
    last_timeout = timeout;
    n_vec++;
    if (a !== e) begin
      n_miss++;
      $display("FAIL cycle_outputs t=%0t actual=%b required=%b (timeout,err,valid,idx,gnt)",
               $time, a, e);
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] p,
                      input logic s, input logic d);
    @(negedge clk);
    req = r; pick = p; xfer_start = s; xfer_done = d;
    exp_q.push_back(model_expect());
    #1;
    compare_outputs();
    @(posedge clk);
    model_advance();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0; pick = '0; xfer_start = 1'b0; xfer_done = 1'b0;
    model_reset();
    #1;
    check_lit("reset_gnt",   32'(gnt), 32'h0);
    check_lit("reset_idx",   32'(gnt_idx), 32'h0);
    check_lit("reset_valid", 32'(gnt_valid), 32'h0);
    check_lit("reset_err",   32'(err), 32'h0);
    check_lit("reset_to",    32'(timeout), 32'h0);
    check_lit("reset_state", 32'(dbg_state), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] r, p;
    logic s, d;
    int sel, hold_pct, xs_pct, first_to, n_to;

    rst = 1'b1; req = '0; pick = '0; xfer_start = 1'b0; xfer_done = 1'b0;
    n_vec = 0; n_miss = 0; last_timeout = 1'b0;
    model_reset();

    // Basic grant / release / re-grant
    do_reset();
    step(4'b0110, 4'b0010, 0, 0); #2;
    check_lit("basic_gnt",   32'(gnt), 32'h2);
    check_lit("basic_idx",   32'(gnt_idx), 32'h1);
    check_lit("basic_valid", 32'(gnt_valid), 32'h1);
    step(4'b0100, 4'b0000, 0, 0); #2;
    check_lit("release_gnt",   32'(gnt), 32'h0);
    check_lit("release_state", 32'(dbg_state), 32'h2);
    step(4'b0100, 4'b0100, 0, 0); #2;
    check_lit("dead_cycle_gnt", 32'(gnt), 32'h0);
    step(4'b0100, 4'b0100, 0, 0); #2;
    check_lit("regrant_gnt", 32'(gnt), 32'h4);
    check_lit("regrant_idx", 32'(gnt_idx), 32'h2);

    // Outstanding hold after request drop
    do_reset();
    step(4'b0001, 4'b0001, 0, 0);
    for (int i = 0; i < 3; i++) step(4'b0001, 4'b0000, 1, 0);
    step(4'b0000, 4'b0000, 0, 0); #2;
    check_lit("outst_held", 32'(gnt), 32'h1);
    step(4'b0000, 4'b0000, 1, 1);
    step(4'b0000, 4'b0000, 0, 1);
    step(4'b0000, 4'b0000, 0, 1); #2;
    check_lit("outst_held2", 32'(gnt), 32'h1);
    step(4'b0000, 4'b0000, 0, 1); #2;
    check_lit("outst_release", 32'(gnt), 32'h0);
    check_lit("outst_err", 32'(err), 32'h0);

    // Hold timeout
    do_reset();
    step(4'b1000, 4'b1000, 0, 0);
    first_to = 0; n_to = 0;
    for (int k = 1; k <= 22; k++) begin
      step(4'b1000, 4'b0000, 0, 0);
      if (last_timeout) begin
        n_to++;
        if (first_to == 0) first_to = k;
      end
      #2;
      if (k == 16) check_lit("timeout_gnt_after", 32'(gnt), 32'h0);
    end
    check_lit("timeout_cycle",  32'(first_to), 32'd16);
    check_lit("timeout_pulses", 32'(n_to), 32'd1);

    // Multi-bit pick error, sticky
    do_reset();
    step(4'b1111, 4'b0101, 0, 0); #2;
    check_lit("badpick_gnt", 32'(gnt), 32'h0);
    check_lit("badpick_err", 32'(err), 32'h1);
    step(4'b0000, 4'b0000, 0, 0);
    step(4'b0000, 4'b0000, 0, 0); #2;
    check_lit("err_sticky", 32'(err), 32'h1);

    // Outstanding overflow
    do_reset();
    step(4'b0100, 4'b0100, 0, 0);
    for (int i = 0; i < 7; i++) step(4'b0100, 4'b0000, 1, 0);
    #2 check_lit("no_ovf_err", 32'(err), 32'h0);
    step(4'b0100, 4'b0000, 1, 0); #2;
    check_lit("ovf_err", 32'(err), 32'h1);
    for (int i = 0; i < 6; i++) step(4'b0000, 4'b0000, 0, 1);
    #2 check_lit("ovf_count_held", 32'(gnt), 32'h4);
    step(4'b0000, 4'b0000, 0, 1); #2;
    check_lit("ovf_drained", 32'(gnt), 32'h0);

    // Stray xfer_start in IDLE
    do_reset();
    step(4'b0000, 4'b0000, 1, 0); #2;
    check_lit("idle_start_err", 32'(err), 32'h1);

    // Async reset mid-transfer (err set beforehand so its clear is visible)
    do_reset();
    step(4'b1111, 4'b0101, 0, 0);
    step(4'b0001, 4'b0001, 0, 0);
    step(4'b0001, 4'b0000, 1, 0);
    step(4'b0001, 4'b0000, 1, 0);
    @(negedge clk); #2;
    rst = 1'b1;
    xfer_start = 1'b0;
    #1;
    check_lit("async_gnt",   32'(gnt), 32'h0);
    check_lit("async_valid", 32'(gnt_valid), 32'h0);
    check_lit("async_err",   32'(err), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(4'b0001, 4'b0001, 0, 0); #2;
    check_lit("post_reset_gnt", 32'(gnt), 32'h1);

    // Pick ignored while owned
    do_reset();
    step(4'b0010, 4'b0010, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step(4'b0010, (k % 2) ? 4'b1000 : 4'b0001, 0, 0); #2;
      check_lit("pick_ignored", 32'(gnt), 32'h2);
    end

    // Randomized traffic against the model
    for (int blk = 0; blk < 8; blk++) begin
      do_reset();
      hold_pct = (blk % 2) ? 80 : 98;
      xs_pct   = (blk >= 6) ? 60 : 25;
      for (int c = 0; c < 250; c++) begin
        r = N'($urandom_range(0, (1 << N) - 1));
        if (m_owner >= 0) r[m_owner] = ($urandom_range(0, 99) < hold_pct);
        sel = $urandom_range(0, 39);
        if (sel < 6) p = '0;
        else if (sel == 6 && blk >= 4) begin
          p = N'($urandom_range(0, (1 << N) - 1));
          if ($countones(p) < 2) p = 4'b0101;
        end else p = N'(1 << $urandom_range(0, N - 1));
        if (m_owner >= 0) s = ($urandom_range(0, 99) < xs_pct);
        else s = (blk >= 4) && ($urandom_range(0, 199) == 0);
        d = ($urandom_range(0, 99) < 30);
        step(r, p, s, d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
